lvt_wr_sched: RTL and testbench

- Write-side front end for lvt_bram; feeds its two write ports (wr0_*, wr1_*).
- Takes write requests from two independent clients over valid/ready and buffers each in a small FIFO.
- Issues at most one write per port per cycle, with fixed mapping: client 0 to wr0, client 1 to wr1.
- Never presents the same address on both ports in one cycle, because the LVT does not define that case. Same-address collisions are serialised with round-robin priority.

---
 rtl/lvt_wr_sched_if.sv | 35 +++
 rtl/lvt_wr_sched.sv | 119 +++++++++++
 tb/tb_lvt_wr_sched.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lvt_wr_sched_if.sv
// Bundle between the two write clients, the scheduler and the lvt_bram write ports.
// The master side is the client/bram environment; the slave side is the scheduler.
interface lvt_wr_sched_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 5
);
    logic              in0_valid;
    logic              in0_ready;
    logic [ADDR_W-1:0] in0_addr;
    logic [DATA_W-1:0] in0_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [ADDR_W-1:0] in1_addr;
    logic [DATA_W-1:0] in1_data;
    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              idle;
    logic [7:0]        coll_cnt;

    modport master (
        output in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
        input  in0_ready, in1_ready, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, idle, coll_cnt
    );

    modport slave (
        input  in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
        output in0_ready, in1_ready, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, idle, coll_cnt
    );
endinterface

// File: rtl/lvt_wr_sched.sv
// Two-client write scheduler for lvt_bram: per-client FIFOs feeding wr0/wr1, with
// same-address collisions serialised round-robin so both ports never hit one address.
module lvt_wr_sched #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    lvt_wr_sched_if.slave     bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        head_valid;
    logic [ADDR_W-1:0] in_addr   [2];
    logic [DATA_W-1:0] in_data   [2];
    logic [ADDR_W-1:0] head_addr [2];
    logic [DATA_W-1:0] head_data [2];

    logic              coll;
    logic              prio_reg;
    logic [7:0]        coll_cnt_reg;
    logic              wr0_en_reg, wr1_en_reg;
    logic [ADDR_W-1:0] wr0_addr_reg, wr1_addr_reg;
    logic [DATA_W-1:0] wr0_data_reg, wr1_data_reg;

    assign in_valid   = {bus.in1_valid, bus.in0_valid};
    assign in_addr[0] = bus.in0_addr;
    assign in_addr[1] = bus.in1_addr;
    assign in_data[0] = bus.in0_data;
    assign in_data[1] = bus.in1_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ADDR_W+DATA_W-1:0] mem_reg [FIFO_DEPTH];
            logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
            logic [PTR_W:0]           count_reg;

            // Ready is derived from the registered occupancy only, so a pop gives no same-cycle credit.
            assign in_ready[gi]   = rst && (count_reg != FULL_CNT);
            assign push[gi]       = in_valid[gi] && in_ready[gi];
            assign head_valid[gi] = (count_reg != '0);
            assign {head_addr[gi], head_data[gi]} = mem_reg[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push[gi])
                    mem_reg[wr_ptr_reg] <= {in_addr[gi], in_data[gi]};
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi])
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop[gi])
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    always_comb begin
        coll = 1'b0;
        pop  = head_valid;
        if (head_valid[0] && head_valid[1] && (head_addr[0] == head_addr[1])) begin
            coll = 1'b1;
            pop  = prio_reg ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr0_en_reg   <= 1'b0;
            wr0_addr_reg <= '0;
            wr0_data_reg <= '0;
            wr1_en_reg   <= 1'b0;
            wr1_addr_reg <= '0;
            wr1_data_reg <= '0;
            prio_reg     <= 1'b0;
            coll_cnt_reg <= 8'd0;
        end else begin
            wr0_en_reg   <= pop[0];
            wr0_addr_reg <= pop[0] ? head_addr[0] : '0;
            wr0_data_reg <= pop[0] ? head_data[0] : '0;
            wr1_en_reg   <= pop[1];
            wr1_addr_reg <= pop[1] ? head_addr[1] : '0;
            wr1_data_reg <= pop[1] ? head_data[1] : '0;
            if (coll) begin
                prio_reg <= ~prio_reg;
                if (coll_cnt_reg != 8'hFF)
                    coll_cnt_reg <= coll_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.in0_ready = in_ready[0];
    assign bus.in1_ready = in_ready[1];
    assign bus.wr0_en    = wr0_en_reg;
    assign bus.wr0_addr  = wr0_addr_reg;
    assign bus.wr0_data  = wr0_data_reg;
    assign bus.wr1_en    = wr1_en_reg;
    assign bus.wr1_addr  = wr1_addr_reg;
    assign bus.wr1_data  = wr1_data_reg;
    assign bus.coll_cnt  = coll_cnt_reg;
    assign bus.idle      = !head_valid[0] && !head_valid[1] && !wr0_en_reg && !wr1_en_reg;
endmodule

// File: tb/tb_lvt_wr_sched.sv
// Randomised check of lvt_wr_sched against a queue-based model of the scheduling rules.
module tb_lvt_wr_sched;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 5;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    req_t q0[$];
    req_t q1[$];
    bit   m_prio = 1'b0;
    int   m_coll = 0;
    int   n_push0 = 0;
    int   n_push1 = 0;

    lvt_wr_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lvt_wr_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic drive(input bit v0, input int a0, input int d0,
                         input bit v1, input int a1, input int d1);
        bus.in0_valid = v0;
        bus.in0_addr  = ADDR_W'(a0);
        bus.in0_data  = DATA_W'(d0);
        bus.in1_valid = v1;
        bus.in1_addr  = ADDR_W'(a1);
        bus.in1_data  = DATA_W'(d1);
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_prio = 1'b0;
        m_coll = 0;
    endtask

    // One clock: predict from the queue heads before the edge, then compare after it.
    task automatic step();
        bit   p0, p1, t0, t1;
        req_t h0, h1, e0, e1;
        p0 = rst && bus.in0_valid && (q0.size() < DEPTH);
        p1 = rst && bus.in1_valid && (q1.size() < DEPTH);
        t0 = 1'b0;
        t1 = 1'b0;
        e0 = '0;
        e1 = '0;
        if (rst) begin
            if (q0.size() > 0 && q1.size() > 0 && q0[0].addr == q1[0].addr) begin
                if (m_prio == 1'b0) t0 = 1'b1; else t1 = 1'b1;
                m_prio = ~m_prio;
                if (m_coll < 255) m_coll++;
            end else begin
                t0 = (q0.size() > 0);
                t1 = (q1.size() > 0);
            end
        end
        if (t0) begin h0 = q0.pop_front(); e0 = h0; end
        if (t1) begin h1 = q1.pop_front(); e1 = h1; end
        if (p0) begin q0.push_back({bus.in0_addr, bus.in0_data}); n_push0++; end
        if (p1) begin q1.push_back({bus.in1_addr, bus.in1_data}); n_push1++; end
        @(posedge clk);
        #1;
        chk("wr0", {bus.wr0_en, bus.wr0_addr, bus.wr0_data}, {t0, e0});
        chk("wr1", {bus.wr1_en, bus.wr1_addr, bus.wr1_data}, {t1, e1});
        chk("ready0", bus.in0_ready, rst && (q0.size() < DEPTH));
        chk("ready1", bus.in1_ready, rst && (q1.size() < DEPTH));
        chk("idle", bus.idle, (q0.size() == 0) && (q1.size() == 0) && !t0 && !t1);
        chk("coll_cnt", bus.coll_cnt, m_coll);
        chk("addr_inv", bus.wr0_en && bus.wr1_en && (bus.wr0_addr == bus.wr1_addr), 1'b0);
        $display("cyc t=%0t wr0=%0b/%0d/%0d wr1=%0b/%0d/%0d coll=%0d",
                 $time, bus.wr0_en, bus.wr0_addr, bus.wr0_data,
                 bus.wr1_en, bus.wr1_addr, bus.wr1_data, bus.coll_cnt);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr0", {bus.wr0_en, bus.wr0_addr, bus.wr0_data}, 0);
        chk("rst_ready", {bus.in0_ready, bus.in1_ready}, 0);
        chk("rst_coll", bus.coll_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single write, then idle
        drive(1, 10, 5, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0);  step(); step();
        // Distinct addresses in parallel
        drive(1, 20, 10, 1, 40, 20); step();
        drive(0, 0, 0, 0, 0, 0);     step(); step();
        // Two collisions, second one favours client 1
        drive(1, 30, 15, 1, 30, 7); step();
        drive(0, 0, 0, 0, 0, 0);    repeat (3) step();
        drive(1, 30, 3, 1, 30, 9);  step();
        drive(0, 0, 0, 0, 0, 0);    repeat (3) step();

        // Backpressure: both clients hammer one address
        n_push0 = 0;
        n_push1 = 0;
        for (int i = 0; i < 40 && (n_push0 < 6 || n_push1 < 6); i++) begin
            drive(n_push0 < 6, 50, n_push0, n_push1 < 6, 50, 16 + n_push1);
            step();
        end
        chk("bp_pushes", {n_push0[7:0], n_push1[7:0]}, {8'd6, 8'd6});
        drive(0, 0, 0, 0, 0, 0);
        repeat (12) step();

        // Random traffic over a tiny address range to provoke collisions
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (12) step();

        // Saturation: every cycle collides
        for (int i = 0; i < 300; i++) begin
            drive(1, 5, $urandom, 1, 5, $urandom);
            step();
        end
        chk("coll_sat", bus.coll_cnt, 255);

        // Reset mid-stream with both FIFOs loaded
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
        chk("mrst_wr", {bus.wr0_en, bus.wr0_addr, bus.wr0_data,
                        bus.wr1_en, bus.wr1_addr, bus.wr1_data}, 0);
        chk("mrst_ready", {bus.in0_ready, bus.in1_ready}, 0);
        chk("mrst_coll", bus.coll_cnt, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_ready", {bus.in0_ready, bus.in1_ready}, 2'b11);
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
